axi_traffic_gen: RTL and testbench
==================================

// Module: axi_traffic_gen
// PURPOSE
//  Parametrised AXI4 master traffic generator; next generation of the LFSR stimulus master.
//  Issues a programmed number of INCR bursts (write-only, read-only or alternating).
//  Keeps up to MAX_OUTS transactions outstanding per direction; AW and W are decoupled.
//  Checks B/R responses and exposes completion/error counters to the spy/monitor bench.
// PARAMETERS
//  ID_WIDTH    4    AXI ID width; IDs = issue sequence number mod 2**ID_WIDTH
//  ADDR_WIDTH  32   address width (>=16)
//  DATA_WIDTH  64   data width (32/64/128); BYTES = DATA_WIDTH/8
//  BURST_LEN   4    beats per burst (1..256); BURST_LEN*BYTES power of 2, <=4096
//  MAX_OUTS    4    max outstanding transactions per direction (1..15)
//  CNT_WIDTH   16   width of txn/status counters
// PORTS
//  clk         in   1            clock
//  rst_n       in   1            asynchronous, active-low reset
//  start       in   1            1-cycle pulse: latch num_txn/mode, begin run (ignored while busy)
//  num_txn     in   CNT_WIDTH    total address-channel transactions to issue (0 = done next cycle)
//  mode        in   2            00 write-only, 01 read-only, 10 alternate W,R,W,R..., 11 = 10
//  busy        out  1            run in progress
//  done        out  1            1-cycle pulse when run completes
//  wr_cmpl     out  CNT_WIDTH    B handshakes this run;  rd_cmpl: out CNT_WIDTH, R bursts (rlast) this run
//  err_cnt     out  CNT_WIDTH    bresp/rresp!=OKAY beats + rlast-position errors (saturating)
//  aw*/w*/b*/ar*/r*  std AXI4 subset: awid,awaddr,awlen,awsize,awburst,awvalid,awready,
//              wdata,wstrb,wlast,wvalid,wready,bid,bresp,bvalid,bready, ar*/r* mirror (rid,rdata,rresp,rlast,rvalid,rready)
// BEHAVIOUR
//  Reset: all valids 0, bready=rready=0, busy=done=0, counters 0, LFSR=32'h1; any run aborted.
//  Top FSM: IDLE -(start)-> RUN -(issued==num_txn && wr_outs==0 && rd_outs==0 && w_pend==0)-> DONE -> IDLE.
//   DONE lasts 1 cycle (done=1); busy=1 in RUN and DONE. start clears wr_cmpl/rd_cmpl/err_cnt.
//  Issue: in RUN while issued<num_txn; next dir per mode (alternate starts with write, toggles
//   only on AW/AR handshake). Dir blocked while its outstanding==MAX_OUTS; no skipping in alternate.
//  AW/AR: valid held with stable payload until ready; awlen=arlen=BURST_LEN-1, size=log2(BYTES),
//   burst=INCR. addr = LFSR[ADDR_WIDTH-1:0] & ~(BURST_LEN*BYTES-1) (never crosses 4KB).
//   LFSR (x^32+x^22+x^2+x+1) advances only on AW/AR handshake.
//  wr_outs ++ on AW hs, -- on B hs (same cycle: unchanged). rd_outs ++ on AR hs, -- on rlast beat.
//  W: per-burst queue (depth MAX_OUTS) of accepted AWs; W beats for a burst start only after its
//   AW hs, in AW order; w_pend = queued bursts not fully sent. W may start the cycle after AW hs.
//   wdata = DATA_WIDTH/32 copies of {seq[15:0], 8'h00, beat[7:0]}; wstrb all 1;
//   wlast on beat BURST_LEN-1; wvalid may stay high back-to-back across bursts.
//  bready=rready=1 in RUN/DONE, 0 in IDLE; B/R arriving in IDLE are ignored (not counted).
//  Checks: bresp!=0 or rresp!=0 -> err_cnt+1 per beat; rlast at beat!=BURST_LEN-1, or missing at
//   BURST_LEN-1 -> err_cnt+1 (beat counter resyncs on rlast). Both in one cycle -> +2. Saturate.
//  Counters wrap never; CNT_WIDTH sizing is the user's responsibility except err_cnt (saturates).
//  rst_n low mid-burst: outputs drop to reset values asynchronously; no completion of the burst.
// TESTING
//  1 mode=00,num_txn=3,BURST_LEN=4, slave always ready, OKAY -> 3 AW, 12 W beats (wlast on 4th,8th,12th),
//    wr_cmpl=3, err_cnt=0, done pulse once, busy low after.
//  2 mode=10,num_txn=4 -> address order AW,AR,AW,AR; wr_cmpl=2, rd_cmpl=2, addrs aligned to 32B.
//  3 MAX_OUTS=2, bvalid withheld -> exactly 2 AWs accepted, awvalid held high, no 3rd hs until B returns.
//  4 slave returns bresp=2'b10 once and rlast on beat 2 of 4 -> err_cnt=2 at done.
//  5 awready/wready/arready random 50% stall -> payloads stable while valid&&!ready, counts as test 1.
//  6 assert rst_n low mid write burst -> all valids 0 immediately; after release new start runs clean.

Source files
------------

// File: rtl/axi_traffic_gen.sv
// axi_traffic_gen
//   AXI4 master traffic generator. After a start pulse it issues num_txn INCR bursts, which are
//   write-only, read-only or alternating write/read. Up to MAX_OUTS transactions may be
//   outstanding in each direction. W data follows accepted AWs in order through a small queue.
//   B and R responses are checked, and completion and error counts are exposed.
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start, num_txn, mode    run control (start is ignored while busy)
//   busy, done              run in progress / 1-cycle completion pulse
//   wr_cmpl, rd_cmpl        B handshakes and R bursts (rlast) completed in this run
//   err_cnt                 bad bresp/rresp beats plus rlast-position errors (saturating)
//   aw*, w*, b*, ar*, r*    AXI4 master subset
module axi_traffic_gen #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned MAX_OUTS   = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CNT_WIDTH-1:0]    num_txn,
    input  logic [1:0]              mode,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    wr_cmpl,
    output logic [CNT_WIDTH-1:0]    rd_cmpl,
    output logic [CNT_WIDTH-1:0]    err_cnt,
    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [ID_WIDTH-1:0]     arid,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [ID_WIDTH-1:0]     rid,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);
    localparam int unsigned BYTES       = DATA_WIDTH / 8;
    localparam int unsigned BURST_BYTES = BURST_LEN * BYTES;
    localparam int unsigned OW          = $clog2(MAX_OUTS + 1);
    localparam int unsigned PW          = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
    localparam int unsigned CW1         = CNT_WIDTH + 1;
    localparam int unsigned COPIES      = DATA_WIDTH / 32;
    localparam logic [7:0]      LAST_BEAT = 8'(BURST_LEN - 1);
    localparam logic [OW-1:0]   OUTS_MAX  = OW'(MAX_OUTS);
    localparam logic [PW-1:0]   PTR_MAX   = PW'(MAX_OUTS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  num_q, issued_q, wr_cmpl_q, rd_cmpl_q, err_q, err_d;
    logic [1:0]            mode_q;
    logic                  alt_q;
    logic [31:0]           lfsr_q, lfsr_nxt;
    logic [OW-1:0]         wr_outs_q, rd_outs_q, wq_cnt_q;
    logic [PW-1:0]         wq_wp_q, wq_rp_q;
    logic [15:0]           wq_seq_q [MAX_OUTS];
    logic [7:0]            w_beat_q, r_beat_q;

    logic issue_read, can_issue, aw_hs, ar_hs, addr_hs, w_hs, w_done, b_hs, r_hs, r_end;
    logic b_dec, r_dec, start_go, active;
    logic b_err, r_err, r_pos;
    logic [1:0]            err_inc;
    logic [CW1-1:0]        err_sum;
    logic [ADDR_WIDTH-1:0] addr_c;
    logic [ID_WIDTH-1:0]   id_c;
    logic                  unused_in;

    assign unused_in = ^{bid, rid, rdata};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PW'(1);
    endfunction

    assign active   = (state_q != StIdle);
    assign busy     = active;
    assign done     = (state_q == StDone);
    assign start_go = (state_q == StIdle) && start;

    // Direction only moves on an address handshake, so a raised valid can never drop or
    // change payload: outstanding counts and the W queue fill only shrink while waiting.
    assign issue_read = (mode_q == 2'b01) || (mode_q[1] && alt_q);
    assign can_issue  = (state_q == StRun) && (issued_q < num_q) &&
                        (issue_read ? (rd_outs_q < OUTS_MAX)
                                    : ((wr_outs_q < OUTS_MAX) && (wq_cnt_q < OUTS_MAX)));

    assign addr_c   = ADDR_WIDTH'(lfsr_q) & ~ADDR_WIDTH'(BURST_BYTES - 1);
    assign id_c     = ID_WIDTH'(issued_q);
    assign lfsr_nxt = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

    assign awvalid = can_issue && !issue_read;
    assign arvalid = can_issue && issue_read;
    assign awid    = id_c;
    assign arid    = id_c;
    assign awaddr  = addr_c;
    assign araddr  = addr_c;
    assign awlen   = LAST_BEAT;
    assign arlen   = LAST_BEAT;
    assign awsize  = 3'($clog2(BYTES));
    assign arsize  = 3'($clog2(BYTES));
    assign awburst = 2'b01;
    assign arburst = 2'b01;

    assign wvalid = (wq_cnt_q != '0);
    assign wlast  = (w_beat_q == LAST_BEAT);
    assign wstrb  = '1;
    assign wdata  = {COPIES{wq_seq_q[wq_rp_q], 8'h00, w_beat_q}};

    assign bready = active;
    assign rready = active;

    assign aw_hs   = awvalid && awready;
    assign ar_hs   = arvalid && arready;
    assign addr_hs = aw_hs || ar_hs;
    assign w_hs    = wvalid && wready;
    assign w_done  = w_hs && wlast;
    assign b_hs    = bvalid && bready;
    assign r_hs    = rvalid && rready;
    assign r_end   = r_hs && rlast;
    // Guard against responses the slave had no request for.
    assign b_dec   = b_hs && (wr_outs_q != '0);
    assign r_dec   = r_end && (rd_outs_q != '0);

    always_comb begin
        b_err   = b_hs && (bresp != 2'b00);
        r_err   = r_hs && (rresp != 2'b00);
        r_pos   = r_hs && (rlast != (r_beat_q == LAST_BEAT));
        err_inc = 2'(b_err) + 2'(r_err) + 2'(r_pos);
        err_sum = {1'b0, err_q} + CW1'(err_inc);
        err_d   = err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = (num_txn == '0) ? StDone : StRun;
            StRun:   if ((issued_q == num_q) && (wr_outs_q == '0) && (rd_outs_q == '0) &&
                         (wq_cnt_q == '0)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            num_q     <= '0;
            mode_q    <= '0;
            issued_q  <= '0;
            alt_q     <= 1'b0;
            lfsr_q    <= 32'h1;
            wr_cmpl_q <= '0;
            rd_cmpl_q <= '0;
            err_q     <= '0;
            r_beat_q  <= '0;
            w_beat_q  <= '0;
            wr_outs_q <= '0;
            rd_outs_q <= '0;
            wq_cnt_q  <= '0;
            wq_wp_q   <= '0;
            wq_rp_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_go) begin
                num_q     <= num_txn;
                mode_q    <= mode;
                issued_q  <= '0;
                alt_q     <= 1'b0;
                wr_cmpl_q <= '0;
                rd_cmpl_q <= '0;
                err_q     <= '0;
                r_beat_q  <= '0;
            end else begin
                if (addr_hs) begin
                    issued_q <= issued_q + CNT_WIDTH'(1);
                    alt_q    <= ~alt_q;
                    lfsr_q   <= lfsr_nxt;
                end
                if (b_hs)  wr_cmpl_q <= wr_cmpl_q + CNT_WIDTH'(1);
                if (r_end) rd_cmpl_q <= rd_cmpl_q + CNT_WIDTH'(1);
                err_q <= err_d;
                // The beat counter resyncs on every rlast, early or late.
                if (r_hs) r_beat_q <= rlast ? 8'd0 : r_beat_q + 8'd1;
            end

            case ({aw_hs, b_dec})
                2'b10:   wr_outs_q <= wr_outs_q + OW'(1);
                2'b01:   wr_outs_q <= wr_outs_q - OW'(1);
                default: ;
            endcase
            case ({ar_hs, r_dec})
                2'b10:   rd_outs_q <= rd_outs_q + OW'(1);
                2'b01:   rd_outs_q <= rd_outs_q - OW'(1);
                default: ;
            endcase
            case ({aw_hs, w_done})
                2'b10:   wq_cnt_q <= wq_cnt_q + OW'(1);
                2'b01:   wq_cnt_q <= wq_cnt_q - OW'(1);
                default: ;
            endcase

            if (aw_hs) wq_wp_q <= ptr_inc(wq_wp_q);
            if (w_hs) begin
                if (wlast) begin
                    w_beat_q <= '0;
                    wq_rp_q  <= ptr_inc(wq_rp_q);
                end else begin
                    w_beat_q <= w_beat_q + 8'd1;
                end
            end
        end
    end

    // Sequence number of each accepted write burst, consumed in AW order by the W channel.
    always_ff @(posedge clk) begin
        if (aw_hs) wq_seq_q[wq_wp_q] <= 16'(issued_q);
    end

    assign wr_cmpl = wr_cmpl_q;
    assign rd_cmpl = rd_cmpl_q;
    assign err_cnt = err_q;
endmodule

// File: tb/tb_axi_traffic_gen.sv
// tb_axi_traffic_gen: directed bench for axi_traffic_gen (MAX_OUTS=2, BURST_LEN=4, 64-bit data).
// A behavioural slave answers AW/W/AR and returns B/R with optional errors and stalls. It
// checks payload stability, IDs, addresses against an LFSR model, and W data and wlast position.
module tb_axi_traffic_gen;
    localparam int unsigned IDW = 4, AW = 32, DW = 64, BL = 4, MO = 2, CW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start;
    logic [CW-1:0]   num_txn;
    logic [1:0]      mode;
    logic            busy, done;
    logic [CW-1:0]   wr_cmpl, rd_cmpl, err_cnt;
    logic [IDW-1:0]  awid, arid, bid, rid;
    logic [AW-1:0]   awaddr, araddr;
    logic [7:0]      awlen, arlen;
    logic [2:0]      awsize, arsize;
    logic [1:0]      awburst, arburst, bresp, rresp;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;

    axi_traffic_gen #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL),
        .MAX_OUTS(MO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_txn(num_txn), .mode(mode),
        .busy(busy), .done(done), .wr_cmpl(wr_cmpl), .rd_cmpl(rd_cmpl), .err_cnt(err_cnt),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // x^32 + x^22 + x^2 + x + 1, shifting left with the feedback bit entering at bit 0.
    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    // Slave knobs and observations
    bit   stall, b_hold, b_err_pend, r_early_pend;
    int   aw_cnt, ar_cnt, w_cnt, wlast_cnt, prot_err, run_seq, w_beat, r_beat;
    logic [31:0] lfsr_m;
    logic [7:0]  ord;
    logic [4:0]  addr_low_or;
    int          aw_seq_q[$];
    logic [3:0]  aw_id_q[$], b_q[$], r_q[$];
    bit          aw_wait, ar_wait, w_wait;
    logic [AW-1:0] aw_sv_addr, ar_sv_addr;
    logic [3:0]    aw_sv_id, ar_sv_id;
    logic [DW-1:0] w_sv_data;
    logic          w_sv_last;

    initial begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; bid = 0; bresp = 0;
        rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0;
                aw_seq_q.delete(); aw_id_q.delete(); b_q.delete(); r_q.delete();
                w_beat = 0; r_beat = 0; aw_wait = 0; ar_wait = 0; w_wait = 0;
                lfsr_m = 32'h1; run_seq = 0;
            end else begin
                awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (!b_hold && b_q.size() != 0) begin
                    bvalid = 1; bid = b_q[0]; bresp = b_err_pend ? 2'b10 : 2'b00;
                end else begin
                    bvalid = 0; bresp = 2'b00;
                end
                if (r_q.size() != 0) begin
                    rvalid = 1; rid = r_q[0]; rdata = {2{32'(r_beat)}}; rresp = 2'b00;
                    rlast = (r_beat == BL - 1) || (r_early_pend && r_beat == 1);
                end else begin
                    rvalid = 0; rlast = 0;
                end
                #1;
                if (start && !busy) begin
                    run_seq = 0; ord = 0; addr_low_or = 0; prot_err = 0;
                    aw_cnt = 0; ar_cnt = 0; w_cnt = 0; wlast_cnt = 0;
                end
                if (awvalid && arvalid) prot_err++;
                // W channel (before AW so a same-edge W for a new AW counts as an error)
                if (w_wait && !(wvalid && wdata == w_sv_data && wlast == w_sv_last)) prot_err++;
                w_wait = wvalid && !wready; w_sv_data = wdata; w_sv_last = wlast;
                if (wvalid && wready) begin
                    w_cnt++;
                    if (wlast) wlast_cnt++;
                    if (aw_seq_q.size() == 0) prot_err++;
                    else begin
                        logic [15:0] s;
                        logic [DW-1:0] exp_w;
                        s = 16'(aw_seq_q[0]);
                        exp_w = {2{s, 8'h00, 8'(w_beat)}};
                        if (wdata !== exp_w || wstrb !== 8'hFF || wlast !== (w_beat == BL - 1))
                            prot_err++;
                        if (w_beat == BL - 1) begin
                            w_beat = 0;
                            void'(aw_seq_q.pop_front());
                            b_q.push_back(aw_id_q.pop_front());
                        end else w_beat++;
                    end
                end
                // AW channel
                if (aw_wait && !(awvalid && awaddr == aw_sv_addr && awid == aw_sv_id))
                    prot_err++;
                aw_wait = awvalid && !awready; aw_sv_addr = awaddr; aw_sv_id = awid;
                if (awvalid && awready) begin
                    aw_cnt++;
                    if (awaddr !== (lfsr_m & ~32'h1F) || awid !== 4'(run_seq) ||
                        awlen !== 8'd3 || awsize !== 3'd3 || awburst !== 2'b01) prot_err++;
                    addr_low_or |= awaddr[4:0];
                    lfsr_m = lfsr_step(lfsr_m);
                    aw_seq_q.push_back(run_seq); aw_id_q.push_back(awid);
                    ord = {ord[6:0], 1'b0}; run_seq++;
                end
                // AR channel
                if (ar_wait && !(arvalid && araddr == ar_sv_addr && arid == ar_sv_id))
                    prot_err++;
                ar_wait = arvalid && !arready; ar_sv_addr = araddr; ar_sv_id = arid;
                if (arvalid && arready) begin
                    ar_cnt++;
                    if (araddr !== (lfsr_m & ~32'h1F) || arid !== 4'(run_seq) ||
                        arlen !== 8'd3 || arsize !== 3'd3 || arburst !== 2'b01) prot_err++;
                    addr_low_or |= araddr[4:0];
                    lfsr_m = lfsr_step(lfsr_m);
                    r_q.push_back(arid);
                    ord = {ord[6:0], 1'b1}; run_seq++;
                end
                if (bvalid && bready) begin
                    void'(b_q.pop_front()); b_err_pend = 0;
                end
                if (rvalid && rready) begin
                    if (rlast) begin
                        void'(r_q.pop_front()); r_beat = 0; r_early_pend = 0;
                    end else r_beat++;
                end
            end
        end
    end

    task automatic start_run(input logic [1:0] m, input logic [15:0] n);
        @(negedge clk);
        mode = m; num_txn = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cyc);
        int ndone = 0;
        bit fin = 0;
        cyc = budget;
        for (int i = 0; i < budget && !fin; i++) begin
            if (done) ndone++;
            if (!busy) begin
                fin = 1; cyc = i;
            end else @(negedge clk);
        end
        check_eq({tag, "_done_pulse"}, ndone, 1);
        check_eq({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int  cyc;
        bit  found;
        start = 0; num_txn = 0; mode = 0;
        stall = 0; b_hold = 0; b_err_pend = 0; r_early_pend = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_valids", {awvalid, wvalid, arvalid}, 0);
        check_eq("rst_readies", {bready, rready}, 0);
        check_eq("rst_counters", {wr_cmpl | rd_cmpl | err_cnt}, 0);
        rst_n = 1;
        @(negedge clk);

        // num_txn=0 completes the cycle after start
        start_run(2'b00, 16'd0);
        wait_done("t0", 10, cyc);
        check_eq("t0_latency", cyc, 1);

        // Write-only, 3 bursts
        start_run(2'b00, 16'd3);
        wait_done("t1", 300, cyc);
        check_eq("t1_aw", aw_cnt, 3);
        check_eq("t1_ar", ar_cnt, 0);
        check_eq("t1_wbeats", w_cnt, 12);
        check_eq("t1_wlast", wlast_cnt, 3);
        check_eq("t1_wr_cmpl", wr_cmpl, 3);
        check_eq("t1_rd_cmpl", rd_cmpl, 0);
        check_eq("t1_err", err_cnt, 0);
        check_eq("t1_proto", prot_err, 0);

        // Alternate, 4 transactions: W,R,W,R
        start_run(2'b10, 16'd4);
        wait_done("t2", 300, cyc);
        check_eq("t2_order", ord[3:0], 4'b0101);
        check_eq("t2_wr_cmpl", wr_cmpl, 2);
        check_eq("t2_rd_cmpl", rd_cmpl, 2);
        check_eq("t2_align", addr_low_or, 0);
        check_eq("t2_proto", prot_err, 0);

        // Read-only
        start_run(2'b01, 16'd2);
        wait_done("t2r", 300, cyc);
        check_eq("t2r_aw", aw_cnt, 0);
        check_eq("t2r_rd_cmpl", rd_cmpl, 2);
        check_eq("t2r_proto", prot_err, 0);

        // Outstanding limit: B withheld, only MAX_OUTS AWs accepted
        b_hold = 1;
        start_run(2'b00, 16'd3);
        repeat (30) @(negedge clk);
        check_eq("t3_aw_blocked", aw_cnt, 2);
        check_eq("t3_w_decoupled", w_cnt, 8);
        check_eq("t3_busy", busy, 1);
        b_hold = 0;
        wait_done("t3", 300, cyc);
        check_eq("t3_aw_final", aw_cnt, 3);
        check_eq("t3_wr_cmpl", wr_cmpl, 3);

        // Error responses: one bresp=SLVERR, one rlast on the 2nd beat of 4
        b_err_pend = 1; r_early_pend = 1;
        start_run(2'b10, 16'd2);
        wait_done("t4", 300, cyc);
        check_eq("t4_err", err_cnt, 2);
        check_eq("t4_wr_cmpl", wr_cmpl, 1);
        check_eq("t4_rd_cmpl", rd_cmpl, 1);

        // Random ready stalls on AW/W/AR
        stall = 1;
        start_run(2'b00, 16'd3);
        wait_done("t5", 2000, cyc);
        stall = 0;
        check_eq("t5_aw", aw_cnt, 3);
        check_eq("t5_wbeats", w_cnt, 12);
        check_eq("t5_wlast", wlast_cnt, 3);
        check_eq("t5_wr_cmpl", wr_cmpl, 3);
        check_eq("t5_err", err_cnt, 0);
        check_eq("t5_proto", prot_err, 0);

        // Reset in the middle of a write burst
        start_run(2'b00, 16'd3);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (w_beat != 0) found = 1;
        end
        check_eq("t6_midburst", found, 1);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        check_eq("t6_valids", {awvalid, wvalid, arvalid}, 0);
        check_eq("t6_readies", {bready, rready}, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_wr_cmpl", wr_cmpl, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        start_run(2'b01, 16'd2);
        wait_done("t6", 300, cyc);
        check_eq("t6_rd_cmpl", rd_cmpl, 2);
        check_eq("t6_err", err_cnt, 0);
        check_eq("t6_ar", ar_cnt, 2);
        check_eq("t6_proto", prot_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
